riscv_decode_stage: RTL and testbench
=====================================

Name: riscv_decode_stage

Overview:
- Registered, flow-controlled RV32 decode stage that succeeds the combinational instruction decoder.
- Accepts fetched instruction/PC over a valid/ready handshake.
- Produces field split, instruction-format class, sign-extended immediate and illegal flag, one cycle later.
- A 2-entry skid buffer gives full throughput under backpressure. Sits between fetch and register-read/execute.

Parameters:
XLEN, 32, datapath width of in_pc/out_pc/out_imm; legal values 32 or 64; immediates sign-extended to XLEN
CNT_WIDTH, 16, width of performance counters (used only with optional feature)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous; discards all buffered entries
in_valid  input  1  upstream instruction valid
in_ready  output  1  stage can accept this cycle
in_instr  input  32  raw instruction word
in_pc  input  XLEN  PC of in_instr
out_valid  output  1  decoded entry valid
out_ready  input  1  downstream accepts
out_opcode  output  7  instr[6:0]
out_rd  output  5  instr[11:7]
out_func3  output  3  instr[14:12]
out_rs1  output  5  instr[19:15]
out_rs2  output  5  instr[24:20]
out_func7  output  7  instr[31:25]
out_fmt  output  3  0=R 1=I 2=S 3=B 4=U 5=J 7=illegal
out_imm  output  XLEN  sign-extended immediate
out_illegal  output  1  unrecognised encoding
out_pc  output  XLEN  passthrough PC
cnt_decoded  output  CNT_WIDTH  entries handed downstream (optional feature)
cnt_illegal  output  CNT_WIDTH  illegal entries handed downstream (optional feature)

Behaviour:
- Reset (rst_n low, async): out_valid=0, skid empty, in_ready=0 while rst_n low, in_ready=1 first cycle after release. All out_* data=0; counters=0.
- Accept when in_valid&&in_ready; transfer out when out_valid&&out_ready. Latency: accepted at edge N -> visible on out_* after edge N, i.e. in cycle N+1.
- Storage: output register (OR) plus skid register (SK). in_ready = !SK_valid, driven from a register; no combinational in_valid/out_ready -> in_ready path.
- State by occupancy: EMPTY (OR, SK empty), ONE (OR full), TWO (OR and SK full).
  - EMPTY: accept -> ONE.
  - ONE: accept & no transfer -> TWO (new entry into SK). Accept & transfer -> ONE (OR reloaded). Transfer only -> EMPTY.
  - TWO: in_ready=0. Transfer -> SK moves to OR, state ONE.
- Order strictly preserved. Output data held stable while out_valid && !out_ready.
- Decode is combinational on the incoming word and registered with it.
- Classification (requires instr[1:0]=2'b11, else illegal):
  - 0110011 -> R
  - 0010011, 0000011, 1100111, 1110011 -> I
  - 0100011 -> S
  - 1100011 -> B
  - 0110111, 0010111 -> U
  - 1101111 -> J
  - all others -> illegal (fmt=7, out_illegal=1, imm=0)
- Immediates are standard RV32 bit assembly, then sign-extended from instr[31] to XLEN:
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U: {instr[31:12], 12'b0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - R: 0
- Field outputs (rd, rs1, ...) are raw slices regardless of format.
- Flush: the next edge clears OR and SK valid and sets in_ready=1. An in_valid in the same cycle as flush is dropped. Flush has priority over accept and transfer.
- Async reset mid-stream: all entries lost immediately, no partial output.

Optional Feature:
- Macro DECODE_PERF_CNT_EN.
- When defined: cnt_decoded increments on each transfer; cnt_illegal increments on each transfer with out_illegal=1. Both saturate at all-ones, are unaffected by flush, and clear only on reset.
- When undefined: no counter flops; cnt_decoded and cnt_illegal tied to 0.

Test Plan:
- in_instr=0x00108093 (ADDI) with out_ready=1 -> next cycle: fmt=1, rd=1, rs1=1, imm=1, illegal=0.
- 0x00B12223 (SW), 0x00B50663 (BEQ) back-to-back -> SW: fmt=2, rs1=2, rs2=11, imm=4; then BEQ: fmt=3, rs1=10, rs2=11, imm=12; one output per cycle.
- 0x0000B537 (LUI), 0x004000EF (JAL), 0xFFF00093 (ADDI -1) -> LUI: fmt=4, rd=10, imm=0x0000B000; JAL: fmt=5, rd=1, imm=4; ADDI: imm=all-ones (XLEN=64 also checked).
- Feed 4 instructions continuously, out_ready=0 for 3 cycles, then 1 -> in_ready low after 2 accepts; all 4 emerge in order; out_* stable while stalled.
- in_instr=0x00000000 and 0x0000007F -> fmt=7, out_illegal=1, imm=0; with DECODE_PERF_CNT_EN, cnt_illegal=2.
- TWO state, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, dropped word never appears; rst_n pulse mid-stream clears out_valid asynchronously.

Source files
------------

// File: rtl/riscv_decode_stage_if.sv
// Fetch-to-decode and decode-to-execute bus for riscv_decode_stage.
// Upstream side:   in_valid, in_ready, in_instr[31:0], in_pc[XLEN-1:0]
// Downstream side: out_valid, out_ready, out_opcode, out_rd, out_func3,
//                  out_rs1, out_rs2, out_func7, out_fmt, out_imm[XLEN-1:0],
//                  out_illegal, out_pc[XLEN-1:0]
// slave modport is the decode stage; master modport is its environment.
interface riscv_decode_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [6:0]      out_opcode;
    logic [4:0]      out_rd;
    logic [2:0]      out_func3;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [6:0]      out_func7;
    logic [2:0]      out_fmt;
    logic [XLEN-1:0] out_imm;
    logic            out_illegal;
    logic [XLEN-1:0] out_pc;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_opcode, out_rd, out_func3, out_rs1,
               out_rs2, out_func7, out_fmt, out_imm, out_illegal, out_pc
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_opcode, out_rd, out_func3, out_rs1,
               out_rs2, out_func7, out_fmt, out_imm, out_illegal, out_pc
    );
endinterface

// File: rtl/riscv_decode_stage.sv
// Registered, flow-controlled RV32 decode stage with a 2-entry skid buffer.
// Ports:
//   clk, rst_n (async active-low), flush (sync, drops all buffered entries)
//   bus         : riscv_decode_stage_if.slave (instruction in, decoded entry out)
//   cnt_decoded : entries handed downstream (saturating)
//   cnt_illegal : illegal entries handed downstream (saturating)
// Optional feature: define DECODE_PERF_CNT_EN to build the performance
// counters; otherwise both counter outputs are tied to zero.
module riscv_decode_stage #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    riscv_decode_stage_if.slave  bus,
    output logic [CNT_WIDTH-1:0] cnt_decoded,
    output logic [CNT_WIDTH-1:0] cnt_illegal
);
    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

    state_t      r_state, w_next_state;
    entry_t      r_or, r_sk, w_in_entry;
    logic        r_out_valid, r_in_ready;
    logic        w_acc, w_xfer;
    logic        w_or_load_in, w_or_load_sk, w_sk_load;
    logic [31:0] w_instr, w_imm32;
    logic [2:0]  w_fmt;
    logic        w_illegal;

    assign w_instr = bus.in_instr;
    // Flush wins over both handshakes, so neither counts as happening.
    assign w_acc   = bus.in_valid && r_in_ready && !flush;
    assign w_xfer  = r_out_valid && bus.out_ready && !flush;

    // Combinational decode of the incoming word.
    always_comb begin
        w_fmt     = FMT_ILL;
        w_imm32   = '0;
        w_illegal = 1'b1;
        if (w_instr[1:0] == 2'b11) begin
            case (w_instr[6:0])
                7'b0110011: begin
                    w_fmt = FMT_R; w_illegal = 1'b0;
                end
                7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                    w_fmt = FMT_I; w_illegal = 1'b0;
                    w_imm32 = {{20{w_instr[31]}}, w_instr[31:20]};
                end
                7'b0100011: begin
                    w_fmt = FMT_S; w_illegal = 1'b0;
                    w_imm32 = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
                end
                7'b1100011: begin
                    w_fmt = FMT_B; w_illegal = 1'b0;
                    w_imm32 = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                               w_instr[30:25], w_instr[11:8], 1'b0};
                end
                7'b0110111, 7'b0010111: begin
                    w_fmt = FMT_U; w_illegal = 1'b0;
                    w_imm32 = {w_instr[31:12], 12'b0};
                end
                7'b1101111: begin
                    w_fmt = FMT_J; w_illegal = 1'b0;
                    w_imm32 = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                               w_instr[20], w_instr[30:21], 1'b0};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_in_entry         = '0;
        w_in_entry.instr   = w_instr;
        w_in_entry.pc      = bus.in_pc;
        w_in_entry.imm     = XLEN'($signed(w_imm32));
        w_in_entry.fmt     = w_fmt;
        w_in_entry.illegal = w_illegal;
    end

    // Occupancy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_EMPTY;
        else        r_state <= w_next_state;
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_acc) w_next_state = ST_ONE;
                ST_ONE: begin
                    if (w_acc && !w_xfer)      w_next_state = ST_TWO;
                    else if (!w_acc && w_xfer) w_next_state = ST_EMPTY;
                end
                ST_TWO:   if (w_xfer) w_next_state = ST_ONE;
                default:  w_next_state = ST_EMPTY;
            endcase
        end
    end

    // Load enables for the output and skid registers.
    always_comb begin
        w_or_load_in = 1'b0;
        w_or_load_sk = 1'b0;
        w_sk_load    = 1'b0;
        case (r_state)
            ST_EMPTY: w_or_load_in = w_acc;
            ST_ONE: begin
                w_or_load_in = w_acc && w_xfer;
                w_sk_load    = w_acc && !w_xfer;
            end
            ST_TWO:   w_or_load_sk = w_xfer;
            default: ;
        endcase
    end

    // Datapath registers; in_ready and out_valid are flopped from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_or        <= '0;
            r_sk        <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
        end else begin
            if (w_or_load_in)      r_or <= w_in_entry;
            else if (w_or_load_sk) r_or <= r_sk;
            if (w_sk_load)         r_sk <= w_in_entry;
            r_out_valid <= (w_next_state != ST_EMPTY);
            r_in_ready  <= (w_next_state != ST_TWO);
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_opcode  = r_or.instr[6:0];
    assign bus.out_rd      = r_or.instr[11:7];
    assign bus.out_func3   = r_or.instr[14:12];
    assign bus.out_rs1     = r_or.instr[19:15];
    assign bus.out_rs2     = r_or.instr[24:20];
    assign bus.out_func7   = r_or.instr[31:25];
    assign bus.out_fmt     = r_or.fmt;
    assign bus.out_imm     = r_or.imm;
    assign bus.out_illegal = r_or.illegal;
    assign bus.out_pc      = r_or.pc;

`ifdef DECODE_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] r_cnt_decoded, r_cnt_illegal;

    // Saturating transfer counters; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_decoded <= '0;
            r_cnt_illegal <= '0;
        end else if (w_xfer) begin
            if (r_cnt_decoded != '1)
                r_cnt_decoded <= r_cnt_decoded + CNT_WIDTH'(1);
            if (r_or.illegal && (r_cnt_illegal != '1))
                r_cnt_illegal <= r_cnt_illegal + CNT_WIDTH'(1);
        end
    end

    assign cnt_decoded = r_cnt_decoded;
    assign cnt_illegal = r_cnt_illegal;
`else
    assign cnt_decoded = '0;
    assign cnt_illegal = '0;
`endif
endmodule

// File: tb/tb_riscv_decode_stage.sv
// Directed bench for riscv_decode_stage: a 32-bit instance is driven directly
// and a 64-bit instance mirrors the same inputs for wide-immediate checks.
module tb_riscv_decode_stage;
    logic clk;
    logic rst_n;
    logic flush;
    logic [15:0] cnt_dec32, cnt_ill32, cnt_dec64, cnt_ill64;
    int total;
    int bad;

`ifdef DECODE_PERF_CNT_EN
    localparam logic [15:0] EXP_ILL = 16'd2;
    localparam logic [15:0] EXP_DEC = 16'd12;
`else
    localparam logic [15:0] EXP_ILL = 16'd0;
    localparam logic [15:0] EXP_DEC = 16'd0;
`endif

    riscv_decode_stage_if #(.XLEN(32)) b32 ();
    riscv_decode_stage_if #(.XLEN(64)) b64 ();

    assign b64.in_valid  = b32.in_valid;
    assign b64.in_instr  = b32.in_instr;
    assign b64.in_pc     = 64'(b32.in_pc);
    assign b64.out_ready = b32.out_ready;

    riscv_decode_stage #(.XLEN(32), .CNT_WIDTH(16)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b32),
        .cnt_decoded(cnt_dec32), .cnt_illegal(cnt_ill32)
    );

    riscv_decode_stage #(.XLEN(64), .CNT_WIDTH(16)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b64),
        .cnt_decoded(cnt_dec64), .cnt_illegal(cnt_ill64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        b32.in_valid = v;
        b32.in_instr = instr;
        b32.in_pc    = pc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; b32.out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        step(); step();
        total++; if (b32.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b want=0", b32.in_ready); end
        total++; if (b32.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", b32.out_valid); end
        total++; if (b32.out_imm !== 32'h0) begin bad++; $display("FAIL rst_out_imm got=%h want=0", b32.out_imm); end
        total++; if (b32.out_pc !== 32'h0) begin bad++; $display("FAIL rst_out_pc got=%h want=0", b32.out_pc); end
        total++; if (cnt_dec32 !== 16'h0) begin bad++; $display("FAIL rst_cnt_decoded got=%h want=0", cnt_dec32); end
        rst_n = 1'b1;
        step();
        total++; if (b32.in_ready !== 1'b1) begin bad++; $display("FAIL rel_in_ready got=%b want=1", b32.in_ready); end
        total++; if (b32.out_valid !== 1'b0) begin bad++; $display("FAIL rel_out_valid got=%b want=0", b32.out_valid); end
    endtask

    task automatic test_addi();
        b32.out_ready = 1'b1;
        drive(1'b1, 32'h00108093, 32'h00000100);
        step();
        total++; if (b32.out_valid !== 1'b1) begin bad++; $display("FAIL addi_valid got=%b want=1", b32.out_valid); end
        total++; if (b32.out_fmt !== 3'd1) begin bad++; $display("FAIL addi_fmt got=%0d want=1", b32.out_fmt); end
        total++; if (b32.out_rd !== 5'd1) begin bad++; $display("FAIL addi_rd got=%0d want=1", b32.out_rd); end
        total++; if (b32.out_rs1 !== 5'd1) begin bad++; $display("FAIL addi_rs1 got=%0d want=1", b32.out_rs1); end
        total++; if (b32.out_imm !== 32'h1) begin bad++; $display("FAIL addi_imm got=%h want=1", b32.out_imm); end
        total++; if (b32.out_illegal !== 1'b0) begin bad++; $display("FAIL addi_illegal got=%b want=0", b32.out_illegal); end
        total++; if (b32.out_opcode !== 7'h13) begin bad++; $display("FAIL addi_opcode got=%h want=13", b32.out_opcode); end
        total++; if (b32.out_pc !== 32'h100) begin bad++; $display("FAIL addi_pc got=%h want=100", b32.out_pc); end
        total++; if (b64.out_pc !== 64'h100) begin bad++; $display("FAIL addi_pc64 got=%h want=100", b64.out_pc); end
        drive(1'b0, 32'h0, 32'h0);
        step();
        total++; if (b32.out_valid !== 1'b0) begin bad++; $display("FAIL addi_drain got=%b want=0", b32.out_valid); end
    endtask

    task automatic test_back_to_back();
        b32.out_ready = 1'b1;
        drive(1'b1, 32'h00B12223, 32'h00000200);
        step();
        total++; if (b32.out_fmt !== 3'd2) begin bad++; $display("FAIL sw_fmt got=%0d want=2", b32.out_fmt); end
        total++; if (b32.out_rs1 !== 5'd2) begin bad++; $display("FAIL sw_rs1 got=%0d want=2", b32.out_rs1); end
        total++; if (b32.out_rs2 !== 5'd11) begin bad++; $display("FAIL sw_rs2 got=%0d want=11", b32.out_rs2); end
        total++; if (b32.out_imm !== 32'h4) begin bad++; $display("FAIL sw_imm got=%h want=4", b32.out_imm); end
        total++; if (b32.out_func3 !== 3'd2) begin bad++; $display("FAIL sw_func3 got=%0d want=2", b32.out_func3); end
        drive(1'b1, 32'h00B50663, 32'h00000204);
        step();
        total++; if (b32.out_valid !== 1'b1) begin bad++; $display("FAIL beq_valid got=%b want=1", b32.out_valid); end
        total++; if (b32.out_fmt !== 3'd3) begin bad++; $display("FAIL beq_fmt got=%0d want=3", b32.out_fmt); end
        total++; if (b32.out_rs1 !== 5'd10) begin bad++; $display("FAIL beq_rs1 got=%0d want=10", b32.out_rs1); end
        total++; if (b32.out_rs2 !== 5'd11) begin bad++; $display("FAIL beq_rs2 got=%0d want=11", b32.out_rs2); end
        total++; if (b32.out_imm !== 32'hC) begin bad++; $display("FAIL beq_imm got=%h want=c", b32.out_imm); end
        total++; if (b32.out_pc !== 32'h204) begin bad++; $display("FAIL beq_pc got=%h want=204", b32.out_pc); end
        drive(1'b0, 32'h0, 32'h0);
        step();
        total++; if (b32.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b want=0", b32.out_valid); end
    endtask

    task automatic test_upper_jump();
        b32.out_ready = 1'b1;
        drive(1'b1, 32'h0000B537, 32'h0);
        step();
        total++; if (b32.out_fmt !== 3'd4) begin bad++; $display("FAIL lui_fmt got=%0d want=4", b32.out_fmt); end
        total++; if (b32.out_rd !== 5'd10) begin bad++; $display("FAIL lui_rd got=%0d want=10", b32.out_rd); end
        total++; if (b32.out_imm !== 32'h0000B000) begin bad++; $display("FAIL lui_imm got=%h want=0000b000", b32.out_imm); end
        total++; if (b64.out_imm !== 64'h0000B000) begin bad++; $display("FAIL lui_imm64 got=%h want=b000", b64.out_imm); end
        drive(1'b1, 32'h004000EF, 32'h0);
        step();
        total++; if (b32.out_fmt !== 3'd5) begin bad++; $display("FAIL jal_fmt got=%0d want=5", b32.out_fmt); end
        total++; if (b32.out_rd !== 5'd1) begin bad++; $display("FAIL jal_rd got=%0d want=1", b32.out_rd); end
        total++; if (b32.out_imm !== 32'h4) begin bad++; $display("FAIL jal_imm got=%h want=4", b32.out_imm); end
        drive(1'b1, 32'hFFF00093, 32'h0);
        step();
        total++; if (b32.out_imm !== 32'hFFFFFFFF) begin bad++; $display("FAIL addim1_imm got=%h want=ffffffff", b32.out_imm); end
        total++; if (b64.out_imm !== 64'hFFFFFFFF_FFFFFFFF) begin bad++; $display("FAIL addim1_imm64 got=%h want=all-ones", b64.out_imm); end
        total++; if (b32.out_func7 !== 7'h7F) begin bad++; $display("FAIL addim1_func7 got=%h want=7f", b32.out_func7); end
        drive(1'b0, 32'h0, 32'h0);
        step();
    endtask

    task automatic test_backpressure();
        b32.out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 32'h0);
        step();
        total++; if (b32.out_rd !== 5'd1) begin bad++; $display("FAIL bp_e1_rd got=%0d want=1", b32.out_rd); end
        total++; if (b32.in_ready !== 1'b1) begin bad++; $display("FAIL bp_e1_in_ready got=%b want=1", b32.in_ready); end
        drive(1'b1, 32'h00200113, 32'h0);
        step();
        total++; if (b32.in_ready !== 1'b0) begin bad++; $display("FAIL bp_e2_in_ready got=%b want=0", b32.in_ready); end
        total++; if (b32.out_rd !== 5'd1) begin bad++; $display("FAIL bp_e2_rd got=%0d want=1", b32.out_rd); end
        drive(1'b1, 32'h00300193, 32'h0);
        step();
        total++; if (b32.in_ready !== 1'b0) begin bad++; $display("FAIL bp_e3_in_ready got=%b want=0", b32.in_ready); end
        total++; if (b32.out_rd !== 5'd1) begin bad++; $display("FAIL bp_e3_rd_stable got=%0d want=1", b32.out_rd); end
        total++; if (b32.out_imm !== 32'h1) begin bad++; $display("FAIL bp_e3_imm_stable got=%h want=1", b32.out_imm); end
        b32.out_ready = 1'b1;
        step();
        total++; if (b32.out_rd !== 5'd2) begin bad++; $display("FAIL bp_e4_rd got=%0d want=2", b32.out_rd); end
        total++; if (b32.in_ready !== 1'b1) begin bad++; $display("FAIL bp_e4_in_ready got=%b want=1", b32.in_ready); end
        step();
        total++; if (b32.out_rd !== 5'd3) begin bad++; $display("FAIL bp_e5_rd got=%0d want=3", b32.out_rd); end
        drive(1'b1, 32'h00400213, 32'h0);
        step();
        total++; if (b32.out_rd !== 5'd4) begin bad++; $display("FAIL bp_e6_rd got=%0d want=4", b32.out_rd); end
        total++; if (b32.out_imm !== 32'h4) begin bad++; $display("FAIL bp_e6_imm got=%h want=4", b32.out_imm); end
        drive(1'b0, 32'h0, 32'h0);
        step();
        total++; if (b32.out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b want=0", b32.out_valid); end
    endtask

    task automatic test_illegal();
        b32.out_ready = 1'b1;
        drive(1'b1, 32'h00000000, 32'h0);
        step();
        total++; if (b32.out_fmt !== 3'd7) begin bad++; $display("FAIL ill0_fmt got=%0d want=7", b32.out_fmt); end
        total++; if (b32.out_illegal !== 1'b1) begin bad++; $display("FAIL ill0_flag got=%b want=1", b32.out_illegal); end
        total++; if (b32.out_imm !== 32'h0) begin bad++; $display("FAIL ill0_imm got=%h want=0", b32.out_imm); end
        drive(1'b1, 32'h0000007F, 32'h0);
        step();
        total++; if (b32.out_fmt !== 3'd7) begin bad++; $display("FAIL ill7f_fmt got=%0d want=7", b32.out_fmt); end
        total++; if (b32.out_illegal !== 1'b1) begin bad++; $display("FAIL ill7f_flag got=%b want=1", b32.out_illegal); end
        total++; if (b64.out_imm !== 64'h0) begin bad++; $display("FAIL ill7f_imm64 got=%h want=0", b64.out_imm); end
        drive(1'b0, 32'h0, 32'h0);
        step();
        total++; if (cnt_ill32 !== EXP_ILL) begin bad++; $display("FAIL cnt_illegal got=%0d want=%0d", cnt_ill32, EXP_ILL); end
        total++; if (cnt_dec32 !== EXP_DEC) begin bad++; $display("FAIL cnt_decoded got=%0d want=%0d", cnt_dec32, EXP_DEC); end
        total++; if (cnt_ill64 !== EXP_ILL) begin bad++; $display("FAIL cnt_illegal64 got=%0d want=%0d", cnt_ill64, EXP_ILL); end
        total++; if (cnt_dec64 !== EXP_DEC) begin bad++; $display("FAIL cnt_decoded64 got=%0d want=%0d", cnt_dec64, EXP_DEC); end
    endtask

    task automatic test_flush();
        b32.out_ready = 1'b0;
        drive(1'b1, 32'h00500293, 32'h0);
        step();
        drive(1'b1, 32'h00600313, 32'h0);
        step();
        total++; if (b32.in_ready !== 1'b0) begin bad++; $display("FAIL fl_two_in_ready got=%b want=0", b32.in_ready); end
        total++; if (b32.out_rd !== 5'd5) begin bad++; $display("FAIL fl_two_rd got=%0d want=5", b32.out_rd); end
        flush = 1'b1;
        drive(1'b1, 32'h00700393, 32'h0);
        step();
        total++; if (b32.out_valid !== 1'b0) begin bad++; $display("FAIL fl_two_valid got=%b want=0", b32.out_valid); end
        total++; if (b32.in_ready !== 1'b1) begin bad++; $display("FAIL fl_two_ready_after got=%b want=1", b32.in_ready); end
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        b32.out_ready = 1'b1;
        step();
        total++; if (b32.out_valid !== 1'b0) begin bad++; $display("FAIL fl_two_no_sk got=%b want=0", b32.out_valid); end
        b32.out_ready = 1'b0;
        drive(1'b1, 32'h00500293, 32'h0);
        step();
        flush = 1'b1;
        drive(1'b1, 32'h00700393, 32'h0);
        step();
        total++; if (b32.out_valid !== 1'b0) begin bad++; $display("FAIL fl_one_valid got=%b want=0", b32.out_valid); end
        total++; if (b32.in_ready !== 1'b1) begin bad++; $display("FAIL fl_one_in_ready got=%b want=1", b32.in_ready); end
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        b32.out_ready = 1'b1;
        step();
        total++; if (b32.out_valid !== 1'b0) begin bad++; $display("FAIL fl_one_dropped got=%b want=0", b32.out_valid); end
        total++; if (cnt_dec32 !== EXP_DEC) begin bad++; $display("FAIL fl_cnt_kept got=%0d want=%0d", cnt_dec32, EXP_DEC); end
    endtask

    task automatic test_async_reset();
        b32.out_ready = 1'b0;
        drive(1'b1, 32'h00800413, 32'h0);
        step();
        total++; if (b32.out_valid !== 1'b1) begin bad++; $display("FAIL ar_pre_valid got=%b want=1", b32.out_valid); end
        drive(1'b0, 32'h0, 32'h0);
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (b32.out_valid !== 1'b0) begin bad++; $display("FAIL ar_valid got=%b want=0", b32.out_valid); end
        total++; if (b32.in_ready !== 1'b0) begin bad++; $display("FAIL ar_in_ready got=%b want=0", b32.in_ready); end
        total++; if (b32.out_rd !== 5'd0) begin bad++; $display("FAIL ar_rd got=%0d want=0", b32.out_rd); end
        total++; if (cnt_dec32 !== 16'h0) begin bad++; $display("FAIL ar_cnt got=%0d want=0", cnt_dec32); end
        step();
        rst_n = 1'b1;
        step();
        total++; if (b32.in_ready !== 1'b1) begin bad++; $display("FAIL ar_rel_in_ready got=%b want=1", b32.in_ready); end
        total++; if (b32.out_valid !== 1'b0) begin bad++; $display("FAIL ar_rel_valid got=%b want=0", b32.out_valid); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_addi();
        test_back_to_back();
        test_upper_jump();
        test_backpressure();
        test_illegal();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
